// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: operand mux select codes, register index width
// and the per-stage destination tracking flags.
package riscv_pkg;

    localparam int REG_ADDR_W = 5;

    // Operand Mux4 port order
    localparam logic [1:0] FWD_SEL_RF    = 2'd0;
    localparam logic [1:0] FWD_SEL_EXMEM = 2'd1;
    localparam logic [1:0] FWD_SEL_MEMWB = 2'd2;
    localparam logic [1:0] FWD_SEL_IMM   = 2'd3;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic is_load;
    } entry_flags_t;

    function automatic logic producer_live(entry_flags_t e);
        return e.valid && e.reg_write;
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand forwarding select and hazard detection against the EX and MEM producers.
// Combinational; FWD_WB_BYPASS_EN enables MEM/WB forwarding, otherwise a MEM match is a hazard.
module fwd_match #(
    parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0]  rs,
    input  logic                   use_imm,
    input  riscv_pkg::entry_flags_t ex_flags,
    input  logic [REG_ADDR_W-1:0]  ex_rd,
    input  riscv_pkg::entry_flags_t mem_flags,
    input  logic [REG_ADDR_W-1:0]  mem_rd,
    output logic [1:0]             sel,
    output logic                   hazard
);
    import riscv_pkg::*;

    logic ex_match;
    logic mem_match;

    always_comb begin
        ex_match  = producer_live(ex_flags)  && (ex_rd  == rs) && (rs != '0);
        mem_match = producer_live(mem_flags) && (mem_rd == rs) && (rs != '0);
    end

    always_comb begin
        sel    = FWD_SEL_RF;
        hazard = 1'b0;
        if (use_imm) begin
            sel = FWD_SEL_IMM;
        end else if (ex_match) begin
            // A load in EX has no data yet; the top turns this into a bubble.
            if (ex_flags.is_load) begin
                hazard = 1'b1;
            end else begin
                sel = FWD_SEL_EXMEM;
            end
        end else if (mem_match) begin
`ifdef FWD_WB_BYPASS_EN
            sel = FWD_SEL_MEMWB;
`else
            hazard = 1'b1;
`endif
        end
    end

endmodule

// File: rtl/operand_fwd_ctrl.sv
// Hazard/forwarding controller: tracks EX/MEM/WB destinations, registers EX operand selects,
// raises a combinational load-use stall and applies flushes. Optional macro: FWD_WB_BYPASS_EN.
module operand_fwd_ctrl #(
    parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_is_load,
    input  logic                  id_use_imm_b,
    input  logic                  flush,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic                  stall,
    output logic                  ex_valid
);
    import riscv_pkg::*;

    entry_flags_t          ex_flags_q,  ex_flags_d;
    entry_flags_t          mem_flags_q, mem_flags_d;
    entry_flags_t          wb_flags_q,  wb_flags_d;
    logic [REG_ADDR_W-1:0] ex_rd_q,  ex_rd_d;
    logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
    logic [REG_ADDR_W-1:0] wb_rd_q,  wb_rd_d;
    logic [1:0]            fwd_sel_a_q, fwd_sel_a_d;
    logic [1:0]            fwd_sel_b_q, fwd_sel_b_d;

    logic [1:0] id_sel_a;
    logic [1:0] id_sel_b;
    logic       haz_a;
    logic       haz_b;
    logic       hazard;
    logic       advance;
    logic       wb_unused;

    fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_a (
        .rs        (id_rs1),
        .use_imm   (1'b0),
        .ex_flags  (ex_flags_q),
        .ex_rd     (ex_rd_q),
        .mem_flags (mem_flags_q),
        .mem_rd    (mem_rd_q),
        .sel       (id_sel_a),
        .hazard    (haz_a)
    );

    // With an immediate operand B, rs2 is not read and cannot cause a hazard.
    fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_b (
        .rs        (id_rs2),
        .use_imm   (id_use_imm_b),
        .ex_flags  (ex_flags_q),
        .ex_rd     (ex_rd_q),
        .mem_flags (mem_flags_q),
        .mem_rd    (mem_rd_q),
        .sel       (id_sel_b),
        .hazard    (haz_b)
    );

    always_comb begin
        hazard  = id_valid && (haz_a || haz_b);
        // A taken branch kills the waiting consumer, so holding it would be pointless.
        stall   = hazard && !flush;
        advance = id_valid && !hazard && !flush;
    end

    always_comb begin
        ex_flags_d.valid     = advance;
        ex_flags_d.reg_write = advance && id_reg_write;
        ex_flags_d.is_load   = advance && id_is_load;
        ex_rd_d              = advance ? id_rd : '0;
        fwd_sel_a_d          = advance ? id_sel_a : FWD_SEL_RF;
        fwd_sel_b_d          = advance ? id_sel_b : FWD_SEL_RF;
        mem_flags_d          = ex_flags_q;
        mem_rd_d             = ex_rd_q;
        wb_flags_d           = mem_flags_q;
        wb_rd_d              = mem_rd_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_flags_q  <= '0;
            mem_flags_q <= '0;
            wb_flags_q  <= '0;
            ex_rd_q     <= '0;
            mem_rd_q    <= '0;
            wb_rd_q     <= '0;
            fwd_sel_a_q <= FWD_SEL_RF;
            fwd_sel_b_q <= FWD_SEL_RF;
        end else begin
            ex_flags_q  <= ex_flags_d;
            mem_flags_q <= mem_flags_d;
            wb_flags_q  <= wb_flags_d;
            ex_rd_q     <= ex_rd_d;
            mem_rd_q    <= mem_rd_d;
            wb_rd_q     <= wb_rd_d;
            fwd_sel_a_q <= fwd_sel_a_d;
            fwd_sel_b_q <= fwd_sel_b_d;
        end
    end

    // WB is tracked for pipeline visibility only: the register file writes before it reads.
    always_comb begin
        wb_unused = ^{wb_flags_q, wb_rd_q};
    end

    always_comb begin
        fwd_sel_a = fwd_sel_a_q;
        fwd_sel_b = fwd_sel_b_q;
        ex_valid  = ex_flags_q.valid;
    end

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Directed bench for operand_fwd_ctrl: a cycle-by-cycle vector table plus stall-count sequences.
module tb_operand_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_is_load;
    logic       id_use_imm_b;
    logic       flush;
    logic [1:0] fwd_sel_a;
    logic [1:0] fwd_sel_b;
    logic       stall;
    logic       ex_valid;

    int checks = 0;
    int errors = 0;

    operand_fwd_ctrl #(.REG_ADDR_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_is_load   (id_is_load),
        .id_use_imm_b (id_use_imm_b),
        .flush        (flush),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .stall        (stall),
        .ex_valid     (ex_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic       imm;
        logic       fl;
        logic       chk_stall;
        logic       e_stall;
        logic [1:0] e_a;
        logic [1:0] e_b;
        logic       e_exv;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string nm, logic r, logic v, logic [4:0] rs1, logic [4:0] rs2,
                                logic [4:0] rd, logic rw, logic ld, logic imm, logic fl,
                                logic ck, logic es, logic [1:0] ea, logic [1:0] eb, logic ex);
        vec_t t;
        t.name = nm; t.rst = r; t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
        t.rw = rw; t.ld = ld; t.imm = imm; t.fl = fl; t.chk_stall = ck; t.e_stall = es;
        t.e_a = ea; t.e_b = eb; t.e_exv = ex;
        vecs.push_back(t);
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic drive(logic r, logic v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                         logic rw, logic ld, logic imm, logic fl);
        rst = r; id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_reg_write = rw; id_is_load = ld; id_use_imm_b = imm; flush = fl;
    endtask

    // Holds the current ID instruction until stall drops, counting stalled cycles,
    // then checks the selects it receives once in EX.
    task automatic measure(string nm, int exp_stalls, int exp_a, int exp_b);
        int stalls = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (!stall) break;
            stalls++;
            @(negedge clk);
        end
        chk({nm, "_stalls"}, stalls, exp_stalls);
        @(posedge clk);
        #1;
        chk({nm, "_sel_a"}, fwd_sel_a, exp_a);
        chk({nm, "_sel_b"}, fwd_sel_b, exp_b);
        chk({nm, "_ex_valid"}, ex_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

        //   name          rst v  rs1 rs2 rd rw ld im fl ck st  a  b exv
        add("reset0",       1, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("reset1",       1, 1,  1,  1,  1, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        add("add_x5",       0, 1,  1,  2,  5, 1, 0, 0, 0, 1, 0, 0, 0, 1);
        add("sub_x6_fwd",   0, 1,  5,  3,  6, 1, 0, 0, 0, 1, 0, 1, 0, 1);
        add("addi_x0",      0, 1,  1,  0,  0, 1, 0, 1, 0, 1, 0, 0, 3, 1);
        add("add_x9_x0",    0, 1,  0,  0,  9, 1, 0, 0, 0, 1, 0, 0, 0, 1);
        add("addi_x10_imm", 0, 1,  0,  0, 10, 1, 0, 1, 0, 1, 0, 0, 3, 1);
        add("add_x4",       0, 1,  1,  2,  4, 1, 0, 0, 0, 1, 0, 0, 0, 1);
        add("or_x4",        0, 1,  1,  2,  4, 1, 0, 0, 0, 1, 0, 0, 0, 1);
        add("and_x11_prio", 0, 1,  4,  4, 11, 1, 0, 0, 0, 1, 0, 1, 1, 1);
        add("lw_x7",        0, 1,  1,  0,  7, 1, 1, 1, 0, 1, 0, 0, 3, 1);
        add("lu_stall1",    0, 1,  7,  7,  8, 1, 0, 0, 0, 1, 1, 0, 0, 0);
`ifdef FWD_WB_BYPASS_EN
        add("lu_retry",     0, 1,  7,  7,  8, 1, 0, 0, 0, 1, 0, 2, 2, 1);
`else
        add("lu_stall2",    0, 1,  7,  7,  8, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        add("lu_retry",     0, 1,  7,  7,  8, 1, 0, 0, 0, 1, 0, 0, 0, 1);
`endif
        add("add_x13_fwd",  0, 1,  8,  0, 13, 1, 0, 0, 0, 1, 0, 1, 0, 1);
        add("lw_x14",       0, 1,  1,  0, 14, 1, 1, 1, 0, 1, 0, 0, 3, 1);
        add("flush_lu",     0, 1, 14, 14, 15, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        add("killed_x15",   0, 1, 15, 15, 12, 1, 0, 0, 0, 1, 0, 0, 0, 1);
        add("wb_no_fwd",    0, 1, 15, 14, 16, 1, 0, 0, 0, 1, 0, 0, 0, 1);
        add("mid_reset",    1, 1, 16,  0, 20, 1, 1, 1, 0, 1, 0, 0, 0, 0);
        add("post_reset",   0, 1, 16, 16, 21, 1, 0, 0, 0, 1, 0, 0, 0, 1);
        add("idle",         0, 0,  0,  0,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                  vecs[i].rw, vecs[i].ld, vecs[i].imm, vecs[i].fl);
            #1;
            if (vecs[i].chk_stall) chk({vecs[i].name, "_stall"}, stall, vecs[i].e_stall);
            @(posedge clk);
            #1;
            chk({vecs[i].name, "_sel_a"}, fwd_sel_a, vecs[i].e_a);
            chk({vecs[i].name, "_sel_b"}, fwd_sel_b, vecs[i].e_b);
            chk({vecs[i].name, "_ex_valid"}, ex_valid, vecs[i].e_exv);
        end

        // Load-use: lw x17 then add x18,x17,x0
        @(negedge clk);
        drive(0, 1, 1, 0, 17, 1, 1, 1, 0);
        @(negedge clk);
        drive(0, 1, 17, 0, 18, 1, 0, 0, 0);
`ifdef FWD_WB_BYPASS_EN
        measure("seq_load_use", 1, 2, 0);
`else
        measure("seq_load_use", 2, 0, 0);
`endif

        // ALU producer two instructions ahead: add x19; bubble; add x20,x0,x19
        @(negedge clk);
        drive(0, 1, 1, 2, 19, 1, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 1, 0, 19, 20, 1, 0, 0, 0);
`ifdef FWD_WB_BYPASS_EN
        measure("seq_alu_gap", 0, 0, 2);
`else
        measure("seq_alu_gap", 1, 0, 0);
`endif

        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
